coherent_mem_ctrl: RTL
======================

Name: coherent_mem_ctrl

Overview:
- Parametrised successor to the 4-port shared memory: NUM_PROCESSORS request channels, round-robin arbitration, one access in flight at a time.
- Keeps a per-block MSI directory (state plus sharer vector).
- Issues invalidations to other processors and waits for their acks before completing a conflicting access.
- After reset, clears memory and directory sequentially, then enters service.

Parameters:
MEM_SIZE, 16384, memory bytes
DATA_SIZE, 2, bytes per data word
BLOCK_SIZE, 2, bytes per block; DEPTH = MEM_SIZE/BLOCK_SIZE, must be a power of 2
NUM_PROCESSORS, 4, request channels (>=2)
ADDR_W, $clog2(MEM_SIZE/BLOCK_SIZE), block address width (13 by default)

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-high reset (1 = reset)
proc_req  in  NUM_PROCESSORS  level request per processor; held until proc_resp
proc_we  in  NUM_PROCESSORS  1 = write, 0 = read
proc_addr  in  NUM_PROCESSORS*ADDR_W  packed block addresses, channel i at [i*ADDR_W +: ADDR_W]
proc_wdata  in  NUM_PROCESSORS*DATA_SIZE*8  packed write data
proc_resp  out  NUM_PROCESSORS  one-cycle completion pulse to the granted channel
mem_read_data  out  DATA_SIZE*8  read data, valid while proc_resp is high
inval_req  out  NUM_PROCESSORS  invalidate-target mask, held until acked
inval_ack  in  NUM_PROCESSORS  invalidate acknowledges (level or pulse)
init_done  out  1  high once the clear sweep has finished

Behaviour:
- Reset (any state, any cycle):
  - FSM goes to INIT; rr_ptr=0; init counter=0.
  - proc_resp=0, inval_req=0, mem_read_data=0, init_done=0.
  - Any in-flight request is dropped with no resp.
- INIT:
  - Each cycle writes memory[cnt]=0 and dir[cnt]={I, sharers=0}, then cnt++.
  - After the write of DEPTH-1, go to IDLE and set init_done=1.
  - Requests are ignored; they stay pending.
- IDLE:
  - If any proc_req is set, pick the first set bit scanning from rr_ptr upward modulo N.
  - Latch id, we, addr, wdata; set rr_ptr = (id+1) mod N; go to LOOKUP.
- LOOKUP: read dir[addr] and compute the target mask.
  - Read, state M, owner != id: target = owner.
  - Write: target = sharers & ~onehot(id).
  - Otherwise target = 0.
  - target != 0 goes to INVAL; target == 0 goes to ACCESS.
- INVAL:
  - inval_req = target.
  - ack_seen |= inval_ack & target; acks from non-targeted channels are ignored.
  - When (ack_seen | (inval_ack & target)) == target, clear inval_req and go to ACCESS on the next edge.
  - There is no timeout.
- ACCESS:
  - Write: memory[addr] = wdata; dir = {M, onehot(id)}.
  - Read: capture memory[addr] to mem_read_data.
    - From I: dir = {S, onehot(id)}.
    - From S: sharers |= onehot(id).
    - From M owned by id: unchanged.
    - From M owned by another processor: after the invalidation, dir = {S, onehot(id)}.
  - Go to RESP.
- RESP:
  - proc_resp[id] = 1 for exactly one cycle, then IDLE.
  - mem_read_data holds its value until the next read completes; writes do not change it.
- Latency: request sampled in IDLE at cycle t gives resp at t+3 with no invalidation; each INVAL cycle adds one.
- Requester rule:
  - The requester must deassert req at the edge where it samples resp=1.
  - A req still high in the following IDLE cycle counts as a new request.
- Simultaneous requests wait in order. A requester whose req drops before grant is simply skipped.
- Memory holds current data (write-through); invalidation needs no data return.

Decomposition:
- Package mem_pkg:
  - coherency_t enum bit[1:0]: I=2'b00, M=2'b01, S=2'b10.
  - ctrl_state_t enum: INIT, IDLE, LOOKUP, INVAL, ACCESS, RESP.
  - Directory entry struct: {coherency_t st; logic [NUM_PROCESSORS-1:0] sharers}.
- Sub-module rr_arbiter #(N):
  - Inputs: req, rr_ptr.
  - Outputs: grant_onehot, grant_idx, any_grant; combinational.
  - rr_ptr update stays in the parent.

Test Plan:
- Reset 3 cycles then release -> init_done rises exactly DEPTH (8192) cycles later; P2 read addr 100 -> resp2 at t+3, data 0x0000, dir[100]={S,0100}.
- P0 write addr 5 = 0xBEEF -> resp0 at t+3, dir[5]={M,0001}; then P1 read addr 5 -> inval_req=0001; ack 2 cycles later -> resp1, data 0xBEEF, dir[5]={S,0010}.
- All four req held continuously (each re-asserting after resp), reads to addrs 10..13 -> grant order 0,1,2,3,0,1; no channel starved.
- P0, P1, P2 read addr 9 (sharers 0111), then P3 write 0x1234 -> inval_req=0111 held; acks for P2, P0, P1 on separate cycles, spurious ack on P3 ignored -> resp3 one cycle after ACCESS, dir[9]={M,1000}.
- P1 owns addr 7 in M; P1 reads then writes addr 7 -> no inval_req asserted, each resp at t+3, state stays M.
- Reset asserted mid-INVAL -> next cycle inval_req=0, no proc_resp, init_done=0, sweep restarts from 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the coherent memory controller: MSI block states and controller FSM states.
package mem_pkg;

    typedef enum bit [1:0] {
        I = 2'b00,
        M = 2'b01,
        S = 2'b10
    } coherency_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        INVAL,
        ACCESS,
        RESP
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above rr_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [IDX_W:0] cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        cand         = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit so rr_ptr + i cannot overflow before the modulo wrap.
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (!any_grant && req[cand[IDX_W-1:0]]) begin
                any_grant                     = 1'b1;
                grant_idx                     = cand[IDX_W-1:0];
                grant_onehot[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherent_mem_ctrl.sv
// Shared memory with an MSI directory: round-robin arbitration, one access in flight,
// invalidations of other holders acknowledged before a conflicting access completes.
module coherent_mem_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_SIZE       = 16384,
    parameter int DATA_SIZE      = 2,
    parameter int BLOCK_SIZE     = 2,
    parameter int NUM_PROCESSORS = 4,
    parameter int ADDR_W         = $clog2(MEM_SIZE / BLOCK_SIZE)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_PROCESSORS-1:0]          proc_req,
    input  logic [NUM_PROCESSORS-1:0]          proc_we,
    input  logic [NUM_PROCESSORS*ADDR_W-1:0]   proc_addr,
    input  logic [NUM_PROCESSORS*DATA_SIZE*8-1:0] proc_wdata,
    output logic [NUM_PROCESSORS-1:0]          proc_resp,
    output logic [DATA_SIZE*8-1:0]             mem_read_data,
    output logic [NUM_PROCESSORS-1:0]          inval_req,
    input  logic [NUM_PROCESSORS-1:0]          inval_ack,
    output logic                               init_done
);

    localparam int DEPTH  = MEM_SIZE / BLOCK_SIZE;
    localparam int DATA_W = DATA_SIZE * 8;
    localparam int ID_W   = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_PROCESSORS - 1);

    typedef struct packed {
        coherency_t                st;
        logic [NUM_PROCESSORS-1:0] sharers;
    } dir_entry_t;

    ctrl_state_t state, state_next;

    logic [ADDR_W-1:0]         init_cnt;
    logic [ID_W-1:0]           rr_ptr;
    logic [NUM_PROCESSORS-1:0] req_onehot;
    logic                      req_we;
    logic [ADDR_W-1:0]         req_addr;
    logic [DATA_W-1:0]         req_wdata;
    logic [NUM_PROCESSORS-1:0] target, lookup_target, ack_seen;
    logic                      acks_done;

    logic [NUM_PROCESSORS-1:0] grant_onehot;
    logic [ID_W-1:0]           grant_idx;
    logic                      any_grant;

    logic [DATA_W-1:0] mem [DEPTH];
    dir_entry_t        dir [DEPTH];
    dir_entry_t        dir_rd, dir_next, dir_wval;
    logic              mem_we, dir_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] mem_wval;

    rr_arbiter #(
        .N     (NUM_PROCESSORS),
        .IDX_W (ID_W)
    ) u_arb (
        .req          (proc_req),
        .rr_ptr       (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_grant    (any_grant)
    );

    // Directory lookup: a read only conflicts with a foreign M owner, a write with every other holder.
    always_comb begin
        dir_rd        = dir[req_addr];
        lookup_target = '0;
        if (req_we) begin
            lookup_target = dir_rd.sharers & ~req_onehot;
        end else if (dir_rd.st == M && dir_rd.sharers != req_onehot) begin
            lookup_target = dir_rd.sharers;
        end
    end

    assign acks_done = ((ack_seen | (inval_ack & target)) == target);

    // Directory contents are untouched during INVAL, so dir_rd still shows the pre-access state here.
    always_comb begin
        dir_next = dir_rd;
        if (req_we) begin
            dir_next = '{st: M, sharers: req_onehot};
        end else begin
            case (dir_rd.st)
                S: dir_next.sharers = dir_rd.sharers | req_onehot;
                M: begin
                    if (dir_rd.sharers != req_onehot) begin
                        dir_next = '{st: S, sharers: req_onehot};
                    end
                end
                default: dir_next = '{st: S, sharers: req_onehot};
            endcase
        end
    end

    // Single write port per array, shared between the clear sweep and the access stage.
    always_comb begin
        mem_we   = 1'b0;
        dir_we   = 1'b0;
        wr_addr  = req_addr;
        mem_wval = req_wdata;
        dir_wval = dir_next;
        if (state == INIT) begin
            mem_we   = 1'b1;
            dir_we   = 1'b1;
            wr_addr  = init_cnt;
            mem_wval = '0;
            dir_wval = '{st: I, sharers: '0};
        end else if (state == ACCESS && !reset_n) begin
            mem_we = req_we;
            dir_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= mem_wval;
        end
        if (dir_we) begin
            dir[wr_addr] <= dir_wval;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        proc_resp  = '0;
        inval_req  = '0;
        case (state)
            INIT:    if (init_cnt == LAST_ADDR) state_next = IDLE;
            IDLE:    if (any_grant) state_next = LOOKUP;
            LOOKUP:  state_next = (lookup_target != '0) ? INVAL : ACCESS;
            INVAL: begin
                inval_req = target;
                if (acks_done) state_next = ACCESS;
            end
            ACCESS:  state_next = RESP;
            RESP: begin
                proc_resp  = req_onehot;
                state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            rr_ptr        <= '0;
            init_cnt      <= '0;
            init_done     <= 1'b0;
            ack_seen      <= '0;
            mem_read_data <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) init_done <= 1'b1;
                end
                IDLE: begin
                    if (any_grant) rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                end
                LOOKUP:  ack_seen <= '0;
                INVAL:   ack_seen <= ack_seen | (inval_ack & target);
                ACCESS: begin
                    if (!req_we) mem_read_data <= mem[req_addr];
                end
                default: ;
            endcase
        end
    end

    // Request capture at grant; these hold for the whole transaction.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_grant) begin
            req_onehot <= grant_onehot;
            req_we     <= proc_we[grant_idx];
            req_addr   <= proc_addr[grant_idx*ADDR_W +: ADDR_W];
            req_wdata  <= proc_wdata[grant_idx*DATA_W +: DATA_W];
        end
        if (state == LOOKUP) begin
            target <= lookup_target;
        end
    end

endmodule
